// File: rtl/f_pc_ctrl.sv
// rtl/f_pc_ctrl.sv - fetch-stage next-PC controller with buffered redirect
module f_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        flush,
    output logic        redir_pending,
    output logic        fetch_misalign
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pend_target;
    logic [31:0] pend_target_next;

    // State register and buffered redirect target; reset drops any pending redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            pend_target <= 32'h0;
        end else begin
            state       <= state_next;
            pend_target <= pend_target_next;
        end
    end

    // Next state: exception/eret discard the buffer, a stalled redirect is captured (newest wins)
    always_comb begin
        state_next       = state;
        pend_target_next = pend_target;
        if (exc_req || eret_req) begin
            state_next = ST_RUN;
        end else if (stall) begin
            if (redir_valid) begin
                state_next       = ST_PEND;
                pend_target_next = redir_target;
            end
        end else begin
            // Any unstalled cycle consumes a live or buffered redirect, or fetches sequentially
            state_next = ST_RUN;
        end
    end

    // Output selection in priority order; outputs are held inert while reset is low
    always_comb begin
        npc   = pc + 32'd4;
        pc_en = 1'b1;
        flush = 1'b0;
        if (!reset) begin
            npc   = RESET_PC;
            pc_en = 1'b0;
        end else if (exc_req) begin
            npc   = HANDLER_PC;
            flush = 1'b1;
        end else if (eret_req) begin
            npc   = epc;
            flush = 1'b1;
        end else if (stall) begin
            npc   = pc;
            pc_en = 1'b0;
        end else if (redir_valid) begin
            npc = redir_target;
        end else if (state == ST_PEND) begin
            npc = pend_target;
        end
    end

    assign redir_pending  = (state == ST_PEND);
    assign fetch_misalign = pc_en & (npc[1:0] != 2'b00);

endmodule

// File: doc/f_pc_ctrl.md
# f_pc_ctrl

Next-PC controller for the fetch stage. Each cycle it chooses the value loaded into the F-stage PC register and drives that register's update enable. It arbitrates between sequential fetch, D-stage branch/jump redirects, M-stage exception entry and `eret` return. A redirect that arrives while fetch is stalled is buffered and applied on the first unstalled cycle.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, fetch address after reset.
- `HANDLER_PC`, 32'h0000_4180, exception/interrupt entry address.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `pc`  in  32  current F-stage PC (PC register output).
- `stall`  in  1  fetch stall from the hazard unit; 1 = hold the PC.
- `redir_valid`  in  1  one-cycle pulse: the D-stage branch was taken or a jump resolved.
- `redir_target`  in  32  redirect address; sampled only when `redir_valid`=1.
- `exc_req`  in  1  M-stage exception/interrupt request (level, one cycle).
- `eret_req`  in  1  M-stage `eret` commit (one cycle).
- `epc`  in  32  return address from CP0; sampled only when `eret_req`=1.
- `npc`  out  32  next PC to the PC register.
- `pc_en`  out  1  PC register update enable.
- `flush`  out  1  flush of the F/D/E pipeline registers.
- `redir_pending`  out  1  a buffered redirect is waiting.
- `fetch_misalign`  out  1  `npc[1:0]`≠0 while `pc_en`=1 (feeds CP0 AdEL).

## Operation
- State machine with two states:
  - RUN: no buffered redirect.
  - PEND: holds a 32-bit `pend_target` register.
- Priority, highest first. Evaluated every cycle, combinationally from inputs and state:
  1. `exc_req`=1: `npc`=HANDLER_PC, `pc_en`=1, `flush`=1, even if `stall`=1. Next state is RUN and any pending redirect is discarded.
  2. `eret_req`=1 (and no `exc_req`): `npc`=`epc`, `pc_en`=1, `flush`=1, even if `stall`=1. Next state is RUN and any pending redirect is discarded.
  3. `stall`=1: `pc_en`=0, `npc`=`pc`.
     - If `redir_valid`=1, capture `redir_target` into `pend_target` and go to PEND.
     - Otherwise keep the current state.
  4. `redir_valid`=1: `npc`=`redir_target`, `pc_en`=1. Next state is RUN. A live redirect supersedes any pending one.
  5. State PEND: `npc`=`pend_target`, `pc_en`=1. Next state is RUN.
  6. Otherwise: `npc`=`pc`+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), `pc_en`=1.
- Delay slot: the branch is in D while its delay slot is in F, so the redirect target is the very next fetch. No extra offset is applied.
- `redir_pending` = (state == PEND).
- `fetch_misalign` = `pc_en` & (`npc[1:0]`≠0). The address is still forwarded unchanged.
- `flush` is never asserted for branch or jump redirects.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to RUN; `pend_target` goes to 0.
  - While held low: `pc_en`=0, `flush`=0, `npc`=RESET_PC, `redir_pending`=0, `fetch_misalign`=0.
  - `reset` may assert mid-PEND; the buffered redirect is lost.
  - First update after deassertion: `npc`=`pc`+4.
- `npc`, `pc_en` and `flush` are combinational (zero latency). The PC register loads `npc` on the same rising edge.
- Buffered redirect: pulse with `stall`=1 at edge N. `redir_pending`=1 after edge N. The target is applied in the first cycle with `stall`=0, loaded at that cycle's edge.
- Simultaneous `exc_req` and `eret_req`: exception wins.
- Second `redir_valid` while PEND and stalled: overwrites `pend_target` (newest wins).

## Test plan
- Sequential fetch: release reset with `pc`=32'h3000, no requests → `npc`=32'h3004, `pc_en`=1, `flush`=0.
- Direct redirect: `pc`=32'h3008, `redir_valid`=1, `redir_target`=32'h3040, `stall`=0 → `npc`=32'h3040, `pc_en`=1, `redir_pending` stays 0.
- Buffered redirect:
  - Stimulus: `stall`=1 with `redir_valid`=1, `redir_target`=32'h3100; hold `stall`=1 for 3 cycles, then release.
  - Response: `pc_en`=0 and `redir_pending`=1 during the stall; on release `npc`=32'h3100 with `pc_en`=1, then `redir_pending`=0.
- Exception overrides stall and pending:
  - Stimulus: state PEND (target 32'h3100), `stall`=1, `exc_req`=1.
  - Response: `npc`=32'h4180, `pc_en`=1, `flush`=1; next cycle unstalled gives `npc`=`pc`+4, not 32'h3100.
- Eret and conflict: `eret_req`=1, `epc`=32'h3020 → `npc`=32'h3020, `flush`=1. Same cycle with `exc_req`=1 → `npc`=32'h4180.
- Misalign and async reset:
  - Stimulus: `redir_target`=32'h3042 with `redir_valid`=1.
  - Response: `npc`=32'h3042 and `fetch_misalign`=1.
  - Then: drop `reset` mid-PEND between edges → `redir_pending`=0 and `pc_en`=0 immediately, without waiting for a clock edge.
